out_mem_uart_dump: RTL and testbench
====================================

OUT_MEM_UART_DUMP -- requirements
Module: out_mem_uart_dump

Interface
REQ-001 The block SHALL have parameter AW, default 10, meaning the word-address width of the output memory read port.
REQ-002 The block SHALL have parameter BAUD_DIV, default 434, meaning clk_50 cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-003 The block SHALL have port clk_50, input, 1, system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, single-cycle dump request.
REQ-006 The block SHALL have port i_out_w, input, 16, output image width in pixels.
REQ-007 The block SHALL have port i_out_h, input, 16, output image height in pixels.
REQ-008 The block SHALL have port mem_raddr, output, AW, word read address into the output memory.
REQ-009 The block SHALL have port mem_rdata, input, 32, read word; registered memory, valid exactly 1 cycle after mem_raddr.
REQ-010 The block SHALL have port tx, output, 1, UART serial line, 8N1, LSB first.
REQ-011 The block SHALL have ports busy, done and err, each output, 1: dump in progress, one-cycle completion pulse, and sticky size-error flag.
REQ-012 The block SHALL have port o_byte_count, output, 32, bytes fully transmitted since the last accepted start.

Function
REQ-013 The dump byte stream SHALL be: 0xA5, W[7:0], W[15:8], H[7:0], H[15:8], then N = W*H pixel bytes in ascending byte index.
REQ-014 Pixel byte index i SHALL be read from word i>>2, lane i[1:0]; lane 0 is rdata[7:0] and lane 3 is rdata[31:24].
REQ-015 W, H and N SHALL be latched on the accepted start; input changes during a dump SHALL have no effect; N is computed as a 32-bit product.
REQ-016 The FSM states SHALL be IDLE, HDR, FETCH, WAIT, SEND and FIN.
REQ-017 In IDLE, start=1 SHALL be accepted; the next cycle busy=1, err=0, o_byte_count=0, and the FSM enters HDR.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 If N==0 or N > 4*2^AW, the block SHALL set err=1, transmit nothing, and pulse done 1 cycle after acceptance, then return to IDLE.
REQ-020 In HDR, the 5 header bytes SHALL each be handed to the serializer in turn; after the last one completes, the FSM enters FETCH with pixel index 0.
REQ-021 FETCH SHALL drive mem_raddr = i>>2 for one cycle, WAIT SHALL capture mem_rdata into a 32-bit holding register on the following cycle, and the FSM then enters SEND.
REQ-022 A memory read SHALL occur only when i[1:0]==0; the other three pixels of a word SHALL come from the holding register (one read per 4 pixels; ceil(N/4) reads total).
REQ-023 mem_raddr SHALL hold its last value outside FETCH.
REQ-024 SEND SHALL transmit one byte as a 10-bit frame (start 0, d0..d7, stop 1), each bit held exactly BAUD_DIV cycles, so a frame is 10*BAUD_DIV cycles.
REQ-025 Consecutive frames SHALL be back-to-back except for the fetch gap of at most 3 cycles when i[1:0]==0; tx SHALL be 1 during every gap.
REQ-026 o_byte_count SHALL increment by 1 in the cycle each stop bit completes.
REQ-027 After the stop bit of pixel N-1 completes, the FSM SHALL enter FIN; FIN SHALL pulse done for 1 cycle, clear busy in the same cycle, and return to IDLE.
REQ-028 A start arriving in the same cycle as the done pulse SHALL be ignored; a start is accepted no earlier than the first IDLE cycle.
REQ-029 err SHALL stay set until the next accepted start.

Reset
REQ-030 While rst_n=0, the block SHALL force tx=1, busy=0, done=0, err=0, o_byte_count=0, mem_raddr=0 and the FSM to IDLE.
REQ-031 An asserted rst_n mid-frame SHALL abort the dump immediately with tx returning to 1 and no partial-frame continuation after release.

Verification
REQ-032 BAUD_DIV=4, W=2, H=2, memory word0=0x44332211, start -> tx bytes A5 02 00 02 00 11 22 33 44; done 1 cycle after the last stop bit; o_byte_count=9; exactly 1 memory read.
REQ-033 W=3, H=3, start -> 14 bytes on tx, 3 memory reads (words 0,1,2), pixel 8 taken from word2 lane 0.
REQ-034 W=0, H=5 -> err=1, done 1 cycle after start, tx constantly 1; AW=10 with W=64, H=65 (N=4160>4096) -> err=1.
REQ-035 A second start pulse mid-dump, plus changes to i_out_w/i_out_h -> stream is unchanged and o_byte_count is unchanged.
REQ-036 Reset during the bit d3 of pixel 1 -> tx=1 and busy=0 at once; a new start after release gives a complete, correct stream.
REQ-037 Bit-timing check: every tx level change falls on a multiple of BAUD_DIV cycles from the frame start, and each frame is exactly 40 cycles at BAUD_DIV=4.

Source files
------------

// File: rtl/out_mem_uart_dump.sv
// out_mem_uart_dump: streams an output image over a UART (8N1, LSB first).
// Stream = 0xA5, W lo, W hi, H lo, H hi, then W*H pixel bytes taken four
// per 32-bit memory word (lane 0 first). One memory read serves four pixels.
module out_mem_uart_dump #(
  parameter int AW       = 10,
  parameter int BAUD_DIV = 434
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          start,
  input  logic [15:0]   i_out_w,
  input  logic [15:0]   i_out_h,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   o_byte_count
);

  typedef enum logic [2:0] {IDLE, HDR, FETCH, WAIT, SEND, FIN} state_t;

  // Largest pixel count the memory can hold (4 bytes per word).
  localparam logic [32:0] MAX_N     = 33'd4 << AW;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t        state_q, state_d;
  logic [31:0]   idx_q, idx_d;
  logic [2:0]    hdr_q, hdr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          err_q, err_d;
  logic [31:0]   cnt_q, cnt_d;

  // Image geometry and the current memory word; no reset needed.
  logic [15:0]   w_q, h_q;
  logic [31:0]   n_q;
  logic [31:0]   hold_q;

  // Serializer state.
  logic [9:0]    sh_q;
  logic [3:0]    bit_q;
  logic [15:0]   baud_q;
  logic          sbusy_q;

  logic          accept;
  logic          ld;
  logic [7:0]    ld_byte;
  logic          ser_done;
  logic [31:0]   n_calc;
  logic          size_bad;
  logic [31:0]   idx_inc;

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic [15:0] w,
                                          input logic [15:0] h);
    case (i)
      3'd0:    hdr_byte = 8'hA5;
      3'd1:    hdr_byte = w[7:0];
      3'd2:    hdr_byte = w[15:8];
      3'd3:    hdr_byte = h[7:0];
      default: hdr_byte = h[15:8];
    endcase
  endfunction

  assign n_calc   = 32'(i_out_w) * 32'(i_out_h);
  assign size_bad = (n_calc == 32'd0) || ({1'b0, n_calc} > MAX_N);
  assign idx_inc  = idx_q + 32'd1;
  assign ser_done = sbusy_q && (baud_q == BAUD_LAST) && (bit_q == 4'd9);

  // Control state register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hdr_q   <= '0;
      raddr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdr_q   <= hdr_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a new byte is loaded in the cycle the previous stop bit
  // ends so frames run back-to-back except across a word fetch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdr_d   = hdr_q;
    raddr_d = raddr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ld      = 1'b0;
    ld_byte = 8'h00;
    if (ser_done) cnt_d = cnt_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          err_d   = size_bad;
          cnt_d   = '0;
          hdr_d   = '0;
          state_d = size_bad ? FIN : HDR;
        end
      end
      HDR: begin
        if (!sbusy_q || ser_done) begin
          if (hdr_q < 3'd5) begin
            ld      = 1'b1;
            ld_byte = hdr_byte(hdr_q, w_q, h_q);
            hdr_d   = hdr_q + 3'd1;
          end else begin
            state_d = FETCH;
            idx_d   = '0;
            raddr_d = '0;
          end
        end
      end
      FETCH: state_d = WAIT;
      WAIT:  state_d = SEND;
      SEND: begin
        if (!sbusy_q) begin
          ld      = 1'b1;
          ld_byte = lane_byte(hold_q, idx_q[1:0]);
        end else if (ser_done) begin
          if (idx_q == n_q - 32'd1) begin
            state_d = FIN;
          end else begin
            idx_d = idx_inc;
            if (idx_inc[1:0] == 2'b00) begin
              state_d = FETCH;
              raddr_d = idx_inc[AW+1:2];
            end else begin
              ld      = 1'b1;
              ld_byte = lane_byte(hold_q, idx_inc[1:0]);
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch geometry on an accepted start and capture the fetched word in WAIT.
  always_ff @(posedge clk_50) begin
    if (accept) begin
      w_q <= i_out_w;
      h_q <= i_out_h;
      n_q <= n_calc;
    end
    if (state_q == WAIT) hold_q <= mem_rdata;
  end

  // UART serializer: 10-bit frame shifted out LSB first, BAUD_DIV cycles per bit.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '1;
      bit_q   <= '0;
      baud_q  <= '0;
      sbusy_q <= 1'b0;
    end else if (ld) begin
      sh_q    <= {1'b1, ld_byte, 1'b0};
      bit_q   <= '0;
      baud_q  <= '0;
      sbusy_q <= 1'b1;
    end else if (sbusy_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_q <= '0;
        sh_q   <= {1'b1, sh_q[9:1]};
        if (bit_q == 4'd9) sbusy_q <= 1'b0;
        else               bit_q   <= bit_q + 4'd1;
      end else begin
        baud_q <= baud_q + 16'd1;
      end
    end
  end

  assign tx           = sh_q[0];
  assign busy         = (state_q == HDR) || (state_q == FETCH) ||
                        (state_q == WAIT) || (state_q == SEND);
  assign done         = (state_q == FIN);
  assign err          = err_q;
  assign o_byte_count = cnt_q;
  assign mem_raddr    = raddr_q;

endmodule

// File: tb/tb_out_mem_uart_dump.sv
// Bench for out_mem_uart_dump: registered memory model, UART frame receiver
// with bit-timing and inter-frame gap checks, and an expected-byte scoreboard.
module tb_out_mem_uart_dump;

  localparam int AW   = 10;
  localparam int BAUD = 4;

  logic          clk_50;
  logic          rst_n;
  logic          start;
  logic [15:0]   i_out_w;
  logic [15:0]   i_out_h;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  logic          tx;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   o_byte_count;

  out_mem_uart_dump #(.AW(AW), .BAUD_DIV(BAUD)) dut (
    .clk_50       (clk_50),
    .rst_n        (rst_n),
    .start        (start),
    .i_out_w      (i_out_w),
    .i_out_h      (i_out_h),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .tx           (tx),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .o_byte_count (o_byte_count)
  );

  logic [31:0] mem [0:(1<<AW)-1];
  logic [7:0]  exp_q [$];
  int          ra_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          rx_frames = 0;
  int          rx_last_end = -1;
  int          rx_cnt = 0;
  logic        rec_en = 1'b0;

  initial begin
    clk_50 = 1'b0;
    forever #10 clk_50 = ~clk_50;
  end

  initial begin
    forever begin
      @(posedge clk_50);
      cyc = cyc + 1;
    end
  end

  // Registered read port: data valid one cycle after the address.
  always @(posedge clk_50) mem_rdata <= mem[mem_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // UART receiver: decodes frames, checks bit-cell alignment and frame gaps.
  initial begin
    logic       act;
    logic       prev;
    logic [9:0] bits;
    int         viol;
    int         gap;
    int         bidx;
    act  = 1'b0;
    prev = 1'b1;
    bits = '0;
    viol = 0;
    forever begin
      @(negedge clk_50);
      if (!rst_n) begin
        act    = 1'b0;
        rx_cnt = 0;
      end else if (!act) begin
        if (tx == 1'b0) begin
          act    = 1'b1;
          rx_cnt = 0;
          viol   = 0;
          bits   = '0;
          bidx   = rx_frames;
          if (rx_last_end >= 0) begin
            gap = cyc - rx_last_end - 1;
            if (bidx >= 5 && ((bidx - 5) % 4) == 0) chk("gap_fetch", 32'(gap <= 3), 1);
            else                                    chk("gap_b2b", gap, 0);
          end
          rx_frames = rx_frames + 1;
        end
      end else begin
        rx_cnt = rx_cnt + 1;
        if (tx != prev && (rx_cnt % BAUD) != 0) viol = viol + 1;
        if ((rx_cnt % BAUD) == BAUD / 2) bits[rx_cnt / BAUD] = tx;
        if (rx_cnt == 10 * BAUD - 1) begin
          act         = 1'b0;
          rx_last_end = cyc;
          chk("bit_timing", viol, 0);
          chk("start_bit", bits[0], 1'b0);
          chk("stop_bit", bits[9], 1'b1);
          if (exp_q.size() == 0) begin
            chk("rx_extra_byte", {24'd0, bits[8:1]}, 32'hFFFF_FFFF);
          end else begin
            chk("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
          end
        end
      end
      prev = tx;
    end
  end

  // Records the sequence of word addresses presented during the pixel phase.
  initial begin
    forever begin
      @(negedge clk_50);
      if (rec_en && busy && o_byte_count >= 32'd5) begin
        if (ra_q.size() == 0 || ra_q[$] != int'(mem_raddr)) ra_q.push_back(int'(mem_raddr));
      end
    end
  end

  task automatic push_dump(input logic [15:0] w, input logic [15:0] h);
    int          n;
    logic [31:0] wd;
    n = int'(w) * int'(h);
    exp_q.push_back(8'hA5);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(h[7:0]);
    exp_q.push_back(h[15:8]);
    for (int i = 0; i < n; i++) begin
      wd = mem[i >> 2];
      exp_q.push_back(wd[(i & 3) * 8 +: 8]);
    end
  endtask

  task automatic arm(input logic [15:0] w, input logic [15:0] h);
    i_out_w     = w;
    i_out_h     = h;
    rx_frames   = 0;
    rx_last_end = -1;
    ra_q.delete();
  endtask

  // Pulse start for one cycle; returns #1 after the accepting edge.
  task automatic pulse_start();
    @(posedge clk_50);
    #1 start = 1'b1;
    @(posedge clk_50);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_50);
      if (done) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int at;
    int lows;
    rst_n   = 1'b0;
    start   = 1'b0;
    i_out_w = 16'd0;
    i_out_h = 16'd0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    mem[0] = 32'h4433_2211;

    // Reset state
    repeat (3) @(posedge clk_50);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_count", o_byte_count, 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    @(negedge clk_50);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_50);

    // 2x2 dump: one word, nine bytes
    arm(16'd2, 16'd2);
    push_dump(16'd2, 16'd2);
    rec_en = 1'b1;
    pulse_start();
    chk("a_busy", busy, 1'b1);
    chk("a_err", err, 1'b0);
    chk("a_count0", o_byte_count, 32'd0);
    wait_done(2000, at);
    chk("a_done_lat", at, rx_last_end + 1);
    chk("a_busy_at_done", busy, 1'b0);
    chk("a_count", o_byte_count, 32'd9);
    chk("a_q_empty", exp_q.size(), 0);
    chk("a_reads", ra_q.size(), 1);
    if (ra_q.size() > 0) chk("a_addr0", ra_q[0], 0);
    // start coinciding with done must be ignored
    start = 1'b1;
    @(posedge clk_50);
    #1 start = 1'b0;
    chk("a_done_pulse", done, 1'b0);
    chk("a_start_in_fin", busy, 1'b0);
    rec_en = 1'b0;
    repeat (3) @(posedge clk_50);

    // 3x3 dump with a spurious start and geometry change mid-stream
    mem[0] = 32'hD4C3_B2A1;
    mem[1] = 32'h8877_6655;
    mem[2] = 32'h0F1E_2D3C;
    mem[3] = 32'hDEAD_BEEF;
    arm(16'd3, 16'd3);
    push_dump(16'd3, 16'd3);
    rec_en = 1'b1;
    pulse_start();
    repeat (100) @(posedge clk_50);
    #1;
    start   = 1'b1;
    i_out_w = 16'd7;
    i_out_h = 16'd9;
    @(posedge clk_50);
    #1 start = 1'b0;
    repeat (150) @(posedge clk_50);
    #1 i_out_w = 16'd1;
    wait_done(3000, at);
    chk("b_done_lat", at, rx_last_end + 1);
    chk("b_count", o_byte_count, 32'd14);
    chk("b_q_empty", exp_q.size(), 0);
    chk("b_reads", ra_q.size(), 3);
    for (int i = 0; i < ra_q.size() && i < 3; i++) chk("b_addr", ra_q[i], i);
    rec_en = 1'b0;
    repeat (3) @(posedge clk_50);

    // Zero-size image: error, immediate done, line idle
    arm(16'd0, 16'd5);
    pulse_start();
    chk("z_done", done, 1'b1);
    chk("z_err", err, 1'b1);
    chk("z_busy", busy, 1'b0);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_50);
      if (tx == 1'b0) lows = lows + 1;
    end
    chk("z_tx_idle", lows, 0);
    chk("z_err_sticky", err, 1'b1);
    chk("z_count", o_byte_count, 32'd0);

    // Oversize image: 64*65 = 4160 > 4096
    arm(16'd64, 16'd65);
    pulse_start();
    chk("o_done", done, 1'b1);
    chk("o_err", err, 1'b1);
    repeat (5) @(posedge clk_50);

    // Reset during d3 of pixel 1, then a clean dump
    mem[0] = 32'h4433_2211;
    arm(16'd2, 16'd2);
    push_dump(16'd2, 16'd2);
    pulse_start();
    chk("r_err_cleared", err, 1'b0);
    at = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_50);
      if (rx_frames == 7 && rx_cnt == 4 * BAUD + 1) begin
        at = k;
        break;
      end
    end
    if (at < 0) chk("r_trigger_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    chk("r_tx", tx, 1'b1);
    chk("r_busy", busy, 1'b0);
    chk("r_count", o_byte_count, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    rst_n = 1'b1;
    repeat (3) @(posedge clk_50);
    arm(16'd2, 16'd2);
    push_dump(16'd2, 16'd2);
    pulse_start();
    wait_done(2000, at);
    chk("r2_count", o_byte_count, 32'd9);
    chk("r2_q_empty", exp_q.size(), 0);
    repeat (5) @(posedge clk_50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
